// File: rtl/bnn_defs.sv
// Shared BNN definitions: X-memory widths, bank selects, layer lengths,
// and the state encodings used by the input loader and X-memory writer.
package bnn_defs;

    localparam int X_ADDR_LEN = 10;
    localparam int X_SEL_LEN  = 2;
    localparam int X_DATA_LEN = 1;

    localparam logic [X_SEL_LEN-1:0] XSEL_L1 = 2'd0;
    localparam logic [X_SEL_LEN-1:0] XSEL_L2 = 2'd1;
    localparam logic [X_SEL_LEN-1:0] XSEL_L3 = 2'd2;
    localparam logic [X_SEL_LEN-1:0] XSEL_L4 = 2'd3;

    // Full network
    localparam int X1_LEN = 784;
    localparam int X2_LEN = 512;
    localparam int X3_LEN = 512;
    localparam int X4_LEN = 512;
    localparam int X5_LEN = 10;

    // Small-net test configuration
    localparam int X1_LEN_SMALL = 2;
    localparam int X2_LEN_SMALL = 2;
    localparam int X3_LEN_SMALL = 2;
    localparam int X4_LEN_SMALL = 2;
    localparam int X5_LEN_SMALL = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_PRESET,
        S_WRITE,
        S_FINISH,
        S_CHECK,
        S_RUN
    } loader_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PRESET,
        W_WRITE,
        W_FINISH
    } wr_state_t;

endpackage

// File: rtl/bnn_xmem_writer.sv
// X-memory strobe sequencer: PRESET -> WRITE (one-cycle x_wq) -> FINISH.
// The caller keeps address and data stable for the whole sequence.
module bnn_xmem_writer
    import bnn_defs::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    output logic o_wq,
    output logic o_last
);

    wr_state_t r_state;
    logic      r_wq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= W_IDLE;
            r_wq    <= 1'b0;
        end else begin
            unique case (r_state)
                W_IDLE: begin
                    r_wq <= 1'b0;
                    if (i_go) r_state <= W_PRESET;
                end
                W_PRESET: begin
                    r_wq    <= 1'b1;
                    r_state <= W_WRITE;
                end
                W_WRITE: begin
                    r_wq    <= 1'b0;
                    r_state <= W_FINISH;
                end
                W_FINISH: begin
                    r_wq    <= 1'b0;
                    r_state <= W_IDLE;
                end
                default: begin
                    r_wq    <= 1'b0;
                    r_state <= W_IDLE;
                end
            endcase
        end
    end

    assign o_wq   = r_wq;
    assign o_last = (r_state == W_FINISH);

endmodule

// File: rtl/bnn_input_loader.sv
// Streams one frame of pixels, binarizes them into X-memory bank 0, then
// enables compute until it finishes. Macro BNN_RUNTIME_THRESH_EN adds thresh_in.
module bnn_input_loader
    import bnn_defs::*;
#(
    parameter int PIX_WIDTH  = 8,
    parameter int X1_LEN     = bnn_defs::X1_LEN,
    parameter int X_ADDR_LEN = bnn_defs::X_ADDR_LEN,
    parameter int X_SEL_LEN  = bnn_defs::X_SEL_LEN,
    parameter int X_DATA_LEN = bnn_defs::X_DATA_LEN,
    parameter int THRESHOLD  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [PIX_WIDTH-1:0]  pix_data,
`ifdef BNN_RUNTIME_THRESH_EN
    input  logic [PIX_WIDTH-1:0]  thresh_in,
`endif
    output logic                  pix_ready,
    output logic [X_DATA_LEN-1:0] wx_write,
    output logic [X_ADDR_LEN-1:0] x_addr,
    output logic [X_SEL_LEN-1:0]  x_sel,
    output logic                  x_wq,
    output logic                  compute_en,
    input  logic                  compute_finish,
    output logic                  busy
);

    localparam logic [PIX_WIDTH-1:0]  THR       = PIX_WIDTH'(THRESHOLD);
    localparam logic [X_ADDR_LEN-1:0] LAST_ADDR = X_ADDR_LEN'(X1_LEN - 1);

    loader_state_t           r_state;
    logic [X_ADDR_LEN-1:0]   r_addr;
    logic                    r_bit;
    logic                    r_en;
    logic                    r_busy;
    logic [PIX_WIDTH-1:0]    w_thresh;
    logic                    w_take;
    logic                    w_bit;
    logic                    w_wq;
    logic                    w_last;

`ifdef BNN_RUNTIME_THRESH_EN
    logic [PIX_WIDTH-1:0] r_thresh;

    // Captured once per frame so mid-frame changes cannot split a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_thresh <= THR;
        end else if (r_state == S_IDLE && start) begin
            r_thresh <= thresh_in;
        end
    end

    assign w_thresh = r_thresh;
`else
    assign w_thresh = THR;
`endif

    assign w_take = (r_state == S_ACCEPT) && pix_valid;
    assign w_bit  = (pix_data >= w_thresh);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_bit   <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCEPT;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                    end
                end
                S_ACCEPT: begin
                    if (w_take) begin
                        r_bit   <= w_bit;
                        r_state <= S_PRESET;
                    end
                end
                S_PRESET: r_state <= S_WRITE;
                S_WRITE:  r_state <= S_FINISH;
                S_FINISH: begin
                    if (w_last) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (r_addr >= LAST_ADDR) begin
                        r_addr  <= '0;
                        r_en    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_ACCEPT;
                    end
                end
                S_RUN: begin
                    if (compute_finish) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    bnn_xmem_writer u_writer (
        .clk    (clk),
        .rst    (rst),
        .i_go   (w_take),
        .o_wq   (w_wq),
        .o_last (w_last)
    );

    assign pix_ready  = (r_state == S_ACCEPT);
    assign wx_write   = X_DATA_LEN'(r_bit);
    assign x_addr     = r_addr;
    assign x_sel      = XSEL_L1;
    assign x_wq       = w_wq;
    assign compute_en = r_en;
    assign busy       = r_busy;

endmodule

// File: doc/bnn_input_loader.md
Name: bnn_input_loader

Overview:
- Upstream feeder for the BNN compute module.
- Accepts one grayscale image as a stream of pixels over valid/ready and binarizes each pixel against a threshold.
- Writes the resulting 1-bit activations into X-memory bank 0 (x_sel=0) using the same preset/write/finish strobe protocol as the compute module.
- When the frame is complete, raises compute_en to launch inference and holds it until compute_finish.

Parameters:
PIX_WIDTH, 8, pixel bit width
X1_LEN, 784, pixels per frame (small-net test: 2)
X_ADDR_LEN, 10, X-memory address width
X_SEL_LEN, 2, X-memory bank select width
X_DATA_LEN, 1, X-memory data width
THRESHOLD, 128, binarization threshold (unsigned)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  one-cycle pulse: begin loading a new frame
pix_valid  in  1  pixel present on pix_data
pix_data  in  PIX_WIDTH  unsigned pixel value
pix_ready  out  1  loader accepts the pixel this cycle
wx_write  out  X_DATA_LEN  binarized bit to X-memory
x_addr  out  X_ADDR_LEN  X-memory write address
x_sel  out  X_SEL_LEN  X-memory bank select, always 0 from this block
x_wq  out  1  X-memory write strobe
compute_en  out  1  level enable to compute module (low = compute reset)
compute_finish  in  1  compute module done
busy  out  1  high from start acceptance until return to IDLE

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; pix_ready=0, wx_write=0, x_addr=0, x_sel=0, x_wq=0, compute_en=0, busy=0; internal address counter=0. Reset mid-frame discards the frame, and compute_en drops on the same edge.
- Binarize: bit = (pix_data >= THRESHOLD) ? 1 : 0, unsigned compare at full PIX_WIDTH.
- FSM states: IDLE, ACCEPT, PRESET, WRITE, FINISH, CHECK, RUN.
- IDLE: if start=1 -> ACCEPT, busy<=1, addr<=0. Otherwise stay.
- ACCEPT: pix_ready=1 (combinational from state). On pix_valid&&pix_ready, latch bit into wx_write -> PRESET. Otherwise stay with no stall limit.
- PRESET: x_addr=addr and wx_write stable, x_wq=0 -> WRITE.
- WRITE: x_wq<=1 for exactly one cycle -> FINISH.
- FINISH: x_wq<=0 -> CHECK. Address and data stay stable one cycle after the strobe falls.
- CHECK: if addr >= X1_LEN-1 -> RUN, addr<=0. Else addr<=addr+1 -> ACCEPT.
- RUN: compute_en<=1, x_wq=0, and x_addr holds 0 (top-level mux gives X-memory to compute). On compute_finish=1 -> IDLE, with compute_en<=0 and busy<=0 on the same edge.
- Throughput: 5 cycles per pixel (ACCEPT with valid, then PRESET, WRITE, FINISH, CHECK).
- Ignored inputs:
  - start while not IDLE is ignored.
  - pix_valid outside ACCEPT is ignored; the upstream source must hold the pixel until pix_ready.
- compute_en is low in every state except RUN, so the compute module sees a clean reset before each frame.
- No address wrap: addr never exceeds X1_LEN-1.

Optional Feature:
- Macro BNN_RUNTIME_THRESH_EN.
- Defined: adds input port thresh_in [PIX_WIDTH-1:0]. It is sampled into a register on the IDLE->ACCEPT transition, and the register is used for the whole frame. Changes mid-frame have no effect. The register resets to THRESHOLD.
- Undefined: no port is added, and the constant THRESHOLD is used.

Decomposition:
- Shared package / header `bnn_defs`:
  - X-memory widths (X_ADDR_LEN, X_SEL_LEN, X_DATA_LEN).
  - Bank select constants XSEL_L1=0, XSEL_L2=1, XSEL_L3=2, XSEL_L4=3.
  - Layer lengths (X1_LEN..X5_LEN) for full and small-net configurations.
  - Loader FSM state encodings.
- One natural sub-module, `bnn_xmem_writer`: the PRESET/WRITE/FINISH strobe sequencer. It is reusable by the compute module's store paths.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then rst=1 with no start -> all outputs 0, pix_ready=0, busy=0 indefinitely.
- Small frame (X1_LEN=2, THRESHOLD=128): start, then pixels 200 and 50 with valid held -> writes addr0=1 and addr1=0. Each x_wq pulse is exactly 1 cycle wide, with addr/data stable from PRESET through FINISH. compute_en rises 5 cycles after the second handshake. Pulse compute_finish -> compute_en=0, busy=0.
- Boundary compare: pixels 128 and 127 -> bits 1 and 0. Pixels 255 and 0 -> bits 1 and 0.
- Backpressure/stall: deassert pix_valid for 7 cycles mid-frame -> FSM waits in ACCEPT with pix_ready=1, no x_wq pulse, and addr unchanged.
- Ignored start / reset mid-frame:
  - start pulses during RUN -> no effect.
  - rst=0 in WRITE state -> next edge x_wq=0, compute_en=0, state IDLE. A new frame then restarts at addr 0.
- BNN_RUNTIME_THRESH_EN defined: thresh_in=10 at start, changed to 250 mid-frame -> pixel 20 still yields 1 for the whole frame.
